// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants for the BCD counter / seven-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int BCD_W = 4;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/seg7_digit_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_decode
// Description : BCD digit plus blank request to active-high segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    input  logic             blank,
    output logic [6:0]       pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank) begin
            unique case (bcd)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_counter_mux.sv
`default_nettype none
// ============================================================================
// Module      : seg7_bcd_counter_mux
// Description : Prescaled multi-digit BCD up/down counter with a scanned
//               seven-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_bcd_counter_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TICK_DIV       = 100000000,
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    tc,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       an
);

    localparam int CW      = BCD_W * DIGITS;
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int REFR_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICK_DIV - 1);
    localparam logic [REFR_W-1:0]  c_refr_max  = REFR_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   c_idx_max   = IDX_W'(DIGITS - 1);
    localparam logic [6:0]         c_seg_off   = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0]  c_an_off    = {DIGITS{AN_ACTIVE_LOW}};

    logic [PRESC_W-1:0] r_presc;
    logic [REFR_W-1:0]  r_refresh;
    logic [IDX_W-1:0]   r_idx;
    logic [CW-1:0]      r_count;
    logic               r_tc;
    logic [6:0]         r_seg;
    logic [DIGITS-1:0]  r_an;

    logic               w_tick;
    logic [CW-1:0]      w_load_bcd;
    logic [CW-1:0]      w_step_bcd;
    logic [DIGITS:0]    w_carry;
    logic [DIGITS-1:0]  w_blank;
    logic [BCD_W-1:0]   w_sel_bcd;
    logic               w_sel_blank;
    logic [DIGITS-1:0]  w_an_onehot;
    logic [6:0]         w_pattern;

    assign w_tick     = en && (r_presc == c_presc_max);
    assign w_carry[0] = 1'b1;

    // w_carry doubles as the borrow chain when counting down
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [BCD_W-1:0] w_d;
        logic [BCD_W-1:0] w_ld;
        logic             w_edge;

        assign w_d    = r_count[gi*BCD_W +: BCD_W];
        assign w_ld   = load_val[gi*BCD_W +: BCD_W];
        assign w_edge = up_dn ? (w_d == 4'd9) : (w_d == 4'd0);

        assign w_load_bcd[gi*BCD_W +: BCD_W] = (w_ld > 4'd9) ? 4'd0 : w_ld;
        assign w_step_bcd[gi*BCD_W +: BCD_W] =
            !w_carry[gi] ? w_d :
            up_dn        ? (w_edge ? 4'd0 : w_d + 4'd1) :
                           (w_edge ? 4'd9 : w_d - 4'd1);
        assign w_carry[gi+1] = w_carry[gi] && w_edge;

        // Blank when this digit and every higher digit are zero
        assign w_blank[gi] = BLANK_LZ && (gi != 0) &&
                             (r_count[CW-1:gi*BCD_W] == '0);
    end

    always_comb begin
        w_sel_bcd   = r_count[BCD_W-1:0];
        w_sel_blank = 1'b0;
        w_an_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_bcd      = r_count[i*BCD_W +: BCD_W];
                w_sel_blank    = w_blank[i];
                w_an_onehot[i] = 1'b1;
            end
        end
    end

    seg7_digit_decode u_decode (
        .bcd     (w_sel_bcd),
        .blank   (w_sel_blank),
        .pattern (w_pattern)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clear || load) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= (r_presc == c_presc_max) ? '0 : r_presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_bcd;
            r_tc    <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_step_bcd;
            r_tc    <= w_carry[DIGITS];
        end else begin
            r_tc    <= 1'b0;
        end
    end

    // Scan runs free of en/clear/load so the display never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == c_refr_max) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == c_idx_max) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_refresh <= r_refresh + REFR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= c_seg_off;
            r_an  <= c_an_off;
        end else begin
            r_seg <= w_pattern ^ c_seg_off;
            r_an  <= w_an_onehot ^ c_an_off;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_counter_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_bcd_counter_mux
// Description : Directed self-checking bench, 2 digits, tick every 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_bcd_counter_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_dn, clear, load;
    logic [7:0] load_val;
    logic [7:0] count, count_al;
    logic       tc, tc_al;
    logic [6:0] seg, seg_al;
    logic [1:0] an, an_al;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg7_bcd_counter_mux #(
        .DIGITS(2), .TICK_DIV(4), .REFRESH_DIV(2),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(count), .tc(tc),
        .seg(seg), .an(an)
    );

    seg7_bcd_counter_mux #(
        .DIGITS(2), .TICK_DIV(4), .REFRESH_DIV(2),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clear(clear),
        .load(load), .load_val(load_val), .count(count_al), .tc(tc_al),
        .seg(seg_al), .an(an_al)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
        load_val = 8'h00;
        repeat (2) @(negedge clk);
        total++; if ({count, tc} !== 9'h000) $display("FAIL reset_count: got %h/%b expected 00/0", count, tc); else passed++;
        total++; if ({seg, an} !== 9'h000) $display("FAIL reset_out_hi: got seg=%h an=%b expected 00/00", seg, an); else passed++;
        total++; if ({seg_al, an_al} !== {7'h7F, 2'b11}) $display("FAIL reset_out_lo: got seg=%h an=%b expected 7f/11", seg_al, an_al); else passed++;
        rst_n = 1'b1;
    endtask

    // Tick at every 4th edge after en rises with the prescaler at 0
    task automatic test_count_up();
        int bad_cnt = 0;
        int bad_tc  = 0;
        en = 1'b1; up_dn = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            total++;
            if (count !== to_bcd((j / 4) % 100)) begin
                bad_cnt++;
                $display("FAIL up_count cyc %0d: got %h expected %h", j, count, to_bcd((j / 4) % 100));
            end else passed++;
            total++;
            if (tc !== (j == 400)) begin
                bad_tc++;
                $display("FAIL up_tc cyc %0d: got %b expected %b", j, tc, (j == 400));
            end else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        load_val = 8'h00; load = 1'b1; up_dn = 1'b0;
        @(negedge clk);
        load = 1'b0;
        total++; if (count !== 8'h00) $display("FAIL dn_load: got %h expected 00", count); else passed++;
        en = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (count !== 8'h00) $display("FAIL dn_pre: got %h expected 00", count); else passed++;
        @(negedge clk);
        total++; if ({count, tc} !== {8'h99, 1'b1}) $display("FAIL dn_wrap: got %h/%b expected 99/1", count, tc); else passed++;
        @(negedge clk);
        total++; if (tc !== 1'b0) $display("FAIL dn_tc_len: got %b expected 0", tc); else passed++;
        repeat (3) @(negedge clk);
        total++; if ({count, tc} !== {8'h98, 1'b0}) $display("FAIL dn_step: got %h/%b expected 98/0", count, tc); else passed++;
    endtask

    task automatic test_clear_load();
        // Prescaler is 0 here; two cycles brings it to 2
        repeat (2) @(negedge clk);
        load_val = 8'h55; load = 1'b1; clear = 1'b1;
        @(negedge clk);
        load = 1'b0; clear = 1'b0; up_dn = 1'b1;
        total++; if ({count, tc} !== 9'h000) $display("FAIL clr_prio: got %h/%b expected 00/0", count, tc); else passed++;
        repeat (3) @(negedge clk);
        total++; if (count !== 8'h00) $display("FAIL clr_presc: got %h expected 00", count); else passed++;
        @(negedge clk);
        total++; if (count !== 8'h01) $display("FAIL clr_tick: got %h expected 01", count); else passed++;
        repeat (2) @(negedge clk);
        load_val = 8'h5C; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        total++; if (count !== 8'h50) $display("FAIL load_sanit: got %h expected 50", count); else passed++;
        repeat (3) @(negedge clk);
        total++; if (count !== 8'h50) $display("FAIL load_presc: got %h expected 50", count); else passed++;
        @(negedge clk);
        total++; if (count !== 8'h51) $display("FAIL load_tick: got %h expected 51", count); else passed++;
    endtask

    task automatic test_enable_hold();
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total++; if (count !== 8'h51) $display("FAIL hold_cnt cyc %0d: got %h expected 51", k, count); else passed++;
        end
        en = 1'b1;
        @(negedge clk);
        total++; if (count !== 8'h51) $display("FAIL hold_resume1: got %h expected 51", count); else passed++;
        @(negedge clk);
        total++; if (count !== 8'h52) $display("FAIL hold_resume2: got %h expected 52", count); else passed++;
        en = 1'b0;
    endtask

    task automatic test_scan();
        logic [1:0] hist [12];
        load_val = 8'h07; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            hist[k] = an;
            total++;
            if (!((an === 2'b01 && seg === 7'h07) || (an === 2'b10 && seg === 7'h00)))
                $display("FAIL scan_seg cyc %0d: got an=%b seg=%h expected 01/07 or 10/00", k, an, seg);
            else passed++;
            total++;
            if (!((an_al === 2'b10 && seg_al === 7'h78) || (an_al === 2'b01 && seg_al === 7'h7F)))
                $display("FAIL scan_seg_al cyc %0d: got an=%b seg=%h expected 10/78 or 01/7f", k, an_al, seg_al);
            else passed++;
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (hist[k] === hist[k+2])
                $display("FAIL scan_period cyc %0d: got an=%b two cycles later expected change from %b", k, hist[k+2], hist[k]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (count_al !== 8'h07) $display("FAIL ar_pre: got %h expected 07", count_al); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({count_al, tc_al} !== 9'h000) $display("FAIL ar_count: got %h/%b expected 00/0", count_al, tc_al); else passed++;
        total++; if ({seg_al, an_al} !== {7'h7F, 2'b11}) $display("FAIL ar_out_lo: got seg=%h an=%b expected 7f/11", seg_al, an_al); else passed++;
        total++; if ({seg, an, count} !== 17'h0) $display("FAIL ar_out_hi: got seg=%h an=%b cnt=%h expected 00/00/00", seg, an, count); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_clear_load();
        test_enable_hold();
        test_scan();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
